// File: rtl/sonic_dist.sv
// Ultrasonic echo-count to centimetre converter with a 4-sample moving average.
// A restoring divider turns the echo cycle count into cm; an out-of-range code bypasses the filter.
module sonic_dist #(
  parameter int unsigned DIVISOR  = 2900,
  parameter logic [23:0] OOR_CODE = 24'h000FFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        in_stb,
  input  logic [23:0] in_count,
  input  logic        clr,
  output logic [11:0] dist_cm,
  output logic        dist_valid,
  output logic        out_of_range,
  output logic        new_flag,
  output logic        overrun,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, DIV, ACC, OUT} state_t;

  localparam logic [24:0] DIV_W = 25'(DIVISOR);

  state_t      state;
  state_t      state_next;

  logic [23:0] quo;
  logic [23:0] rem;
  logic [4:0]  bit_cnt;
  logic        oor;

  logic [11:0] buffer [4];
  logic [1:0]  wr_ptr;
  logic [13:0] sum;
  logic [2:0]  fill;

  logic        accept;
  logic [24:0] rem_shift;
  logic        ge;
  logic [23:0] rem_next;
  logic [23:0] quo_next;
  logic [11:0] q_sat;
  logic [11:0] evict;
  logic [13:0] sum_next;
  logic [2:0]  fill_next;
  logic        set_valid;
  logic        set_overrun;

  assign accept      = en && in_stb && (state == IDLE);
  assign busy        = (state != IDLE);
  assign set_overrun = en && in_stb && busy;
  assign set_valid   = (state == ACC) || ((state == OUT) && oor);

  // The dividend shifts out of quo's MSB while quotient bits enter at its LSB.
  always_comb begin
    rem_shift = {rem, quo[23]};
    ge        = (rem_shift >= DIV_W);
    rem_next  = 24'(rem_shift - (ge ? DIV_W : 25'd0));
    quo_next  = {quo[22:0], ge};
  end

  always_comb begin
    q_sat     = (|quo[23:12]) ? 12'hFFF : quo[11:0];
    evict     = buffer[wr_ptr];
    fill_next = (fill == 3'd4) ? 3'd4 : fill + 3'd1;
    sum_next  = sum + {2'b00, q_sat} - ((fill == 3'd4) ? {2'b00, evict} : 14'd0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_next = (in_count == OOR_CODE) ? OUT : DIV;
        end
      end
      DIV: begin
        if (bit_cnt == 5'd23) begin
          state_next = ACC;
        end
      end
      ACC:     state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      quo          <= '0;
      rem          <= '0;
      bit_cnt      <= '0;
      oor          <= 1'b0;
      wr_ptr       <= '0;
      sum          <= '0;
      fill         <= '0;
      dist_cm      <= '0;
      dist_valid   <= 1'b0;
      out_of_range <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        buffer[i] <= '0;
      end
    end else begin
      dist_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            quo     <= in_count;
            rem     <= '0;
            bit_cnt <= '0;
            oor     <= (in_count == OOR_CODE);
          end
        end
        DIV: begin
          quo     <= quo_next;
          rem     <= rem_next;
          bit_cnt <= bit_cnt + 5'd1;
        end
        ACC: begin
          buffer[wr_ptr] <= q_sat;
          sum            <= sum_next;
          fill           <= fill_next;
          wr_ptr         <= wr_ptr + 2'd1;
          dist_cm        <= (fill_next == 3'd4) ? sum_next[13:2] : q_sat;
          out_of_range   <= 1'b0;
          dist_valid     <= 1'b1;
        end
        OUT: begin
          // Out-of-range samples report here, leaving the filter state untouched.
          if (oor) begin
            out_of_range <= 1'b1;
            dist_valid   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as clr takes priority.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      new_flag <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (set_valid) begin
        new_flag <= 1'b1;
      end else if (clr) begin
        new_flag <= 1'b0;
      end
      if (set_overrun) begin
        overrun <= 1'b1;
      end else if (clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sonic_dist.sv
// Directed self-checking bench for sonic_dist: latency, averaging, out-of-range,
// overrun, enable gating, saturation and reset abort.
module tb_sonic_dist;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic        in_stb = 1'b0;
  logic [23:0] in_count = '0;
  logic        clr = 1'b0;
  logic [11:0] dist_cm;
  logic        dist_valid;
  logic        out_of_range;
  logic        new_flag;
  logic        overrun;
  logic        busy;

  int n_pass = 0;
  int n_total = 0;
  int lat;
  int pulses;
  logic busy_mid;

  sonic_dist #(.DIVISOR(2900), .OOR_CODE(24'h000FFF)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (en),
    .in_stb       (in_stb),
    .in_count     (in_count),
    .clr          (clr),
    .dist_cm      (dist_cm),
    .dist_valid   (dist_valid),
    .out_of_range (out_of_range),
    .new_flag     (new_flag),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Strobe one sample in cycle T, then watch 40 cycles; optionally re-strobe or reset at T+k.
  task automatic run_sample(input logic [23:0] c, input logic en_v, input int extra_at, input int rst_at);
    @(negedge clk);
    in_count = c;
    en       = en_v;
    in_stb   = 1'b1;
    lat      = -1;
    pulses   = 0;
    busy_mid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (dist_valid) begin
        pulses++;
        if (lat < 0) lat = k;
      end
      if (k == 5) busy_mid = busy;
      in_stb  = (k == extra_at);
      reset_n = (k != rst_at);
    end
    en = 1'b1;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    do_reset();
    check("rst_dist", 32'(dist_cm), 0);
    check("rst_valid", 32'(dist_valid), 0);
    check("rst_oor", 32'(out_of_range), 0);
    check("rst_new", 32'(new_flag), 0);
    check("rst_ovr", 32'(overrun), 0);
    check("rst_busy", 32'(busy), 0);

    // Single sample of 100 cm
    run_sample(24'd290000, 1'b1, 0, 0);
    check("s100_lat", lat, 26);
    check("s100_pulses", pulses, 1);
    check("s100_busy", 32'(busy_mid), 1);
    check("s100_dist", 32'(dist_cm), 100);
    check("s100_oor", 32'(out_of_range), 0);
    check("s100_new", 32'(new_flag), 1);
    pulse_clr();
    check("clr_new", 32'(new_flag), 0);

    // Moving average fill and wrap
    do_reset();
    run_sample(24'd29000, 1'b1, 0, 0);
    check("avg1_dist", 32'(dist_cm), 10);
    run_sample(24'd58000, 1'b1, 0, 0);
    check("avg2_dist", 32'(dist_cm), 20);
    run_sample(24'd87000, 1'b1, 0, 0);
    check("avg3_dist", 32'(dist_cm), 30);
    run_sample(24'd116000, 1'b1, 0, 0);
    check("avg4_dist", 32'(dist_cm), 25);
    check("avg4_lat", lat, 26);
    run_sample(24'd145000, 1'b1, 0, 0);
    check("avg5_dist", 32'(dist_cm), 35);

    // Out-of-range code bypasses the filter
    run_sample(24'h000FFF, 1'b1, 0, 0);
    check("oor_lat", lat, 2);
    check("oor_pulses", pulses, 1);
    check("oor_flag", 32'(out_of_range), 1);
    check("oor_dist", 32'(dist_cm), 35);
    run_sample(24'd29000, 1'b1, 0, 0);
    check("after_oor_flag", 32'(out_of_range), 0);
    check("after_oor_dist", 32'(dist_cm), 32);

    // Overrun: second strobe at T+10 is dropped
    pulse_clr();
    run_sample(24'd58000, 1'b1, 10, 0);
    check("ovr_pulses", pulses, 1);
    check("ovr_dist", 32'(dist_cm), 30);
    check("ovr_flag", 32'(overrun), 1);
    check("ovr_new", 32'(new_flag), 1);
    pulse_clr();
    check("ovr_clr", 32'(overrun), 0);
    check("ovr_clr_new", 32'(new_flag), 0);

    // Enable low: strobe ignored
    run_sample(24'd290000, 1'b0, 0, 0);
    check("en0_pulses", pulses, 0);
    check("en0_dist", 32'(dist_cm), 30);
    check("en0_new", 32'(new_flag), 0);
    check("en0_ovr", 32'(overrun), 0);

    // Boundaries: below one cm, saturation
    do_reset();
    run_sample(24'd2899, 1'b1, 0, 0);
    check("lo_dist", 32'(dist_cm), 0);
    check("lo_pulses", pulses, 1);
    run_sample(24'hFFFFFF, 1'b1, 0, 0);
    check("sat_dist", 32'(dist_cm), 4095);
    check("sat_oor", 32'(out_of_range), 0);

    // Reset mid-conversion aborts without a pulse
    run_sample(24'd290000, 1'b1, 0, 12);
    check("abort_pulses", pulses, 0);
    check("abort_dist", 32'(dist_cm), 0);
    check("abort_new", 32'(new_flag), 0);
    check("abort_oor", 32'(out_of_range), 0);
    check("abort_ovr", 32'(overrun), 0);
    check("abort_busy", 32'(busy), 0);
    run_sample(24'd29000, 1'b1, 0, 0);
    check("post_abort_dist", 32'(dist_cm), 10);
    check("post_abort_lat", lat, 26);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
